// File: rtl/byte_pair_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_pair_packer
// Purpose  : Pairs qualified bytes into 16-bit words, buffers them in a FIFO
//            and drops (with sticky flag and saturating count) when full.
// Revision : 1.0 - initial release
// ============================================================================
module byte_pair_packer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_byte,
    input  logic                     in_valid,
    output logic [15:0]              out_word,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count,
    input  logic                     clear
);

    localparam int                  c_ADDR_W     = $clog2(DEPTH);
    localparam logic [0:0]          c_EMPTY_HALF = 1'b0;
    localparam logic [0:0]          c_HAVE_HIGH  = 1'b1;
    localparam logic [c_ADDR_W:0]   c_FULL       = (c_ADDR_W+1)'(DEPTH);
    localparam logic [c_ADDR_W:0]   c_LVL_ONE    = (c_ADDR_W+1)'(1);
    localparam logic [c_ADDR_W-1:0] c_PTR_ONE    = c_ADDR_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX    = {CNT_W{1'b1}};

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [7:0]          r_half;
    logic                w_load_high;
    logic                w_pair_done;

    logic [15:0]         r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_level;
    logic [c_ADDR_W:0]   w_level_nxt;
    logic                r_valid;
    logic                r_overflow;
    logic [CNT_W-1:0]    r_drop_count;

    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    // Pairing FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_EMPTY_HALF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pairing FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (in_valid) begin
            w_state_nxt = (r_state == c_EMPTY_HALF) ? c_HAVE_HIGH : c_EMPTY_HALF;
        end
    end

    // Pairing FSM: outputs
    always_comb begin
        w_load_high = 1'b0;
        w_pair_done = 1'b0;
        if (in_valid) begin
            if (r_state == c_EMPTY_HALF) begin
                w_load_high = 1'b1;
            end else begin
                w_pair_done = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_half <= 8'h00;
        end else if (w_load_high) begin
            r_half <= in_byte;
        end
    end

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_pop  = r_valid && out_ready;
    assign w_push = w_pair_done && ((r_level != c_FULL) || w_pop);
    assign w_drop = w_pair_done && !w_push;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + c_LVL_ONE;
            2'b01:   w_level_nxt = r_level - c_LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 16'h0000;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_half, in_byte};
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_level <= w_level_nxt;
            r_valid <= (w_level_nxt != '0);
        end
    end

    // A drop in the same cycle as clear takes precedence over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clear) begin
                r_drop_count <= c_CNT_ONE;
            end else if (r_drop_count != c_CNT_MAX) begin
                r_drop_count <= r_drop_count + c_CNT_ONE;
            end
        end else if (clear) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign out_word   = r_valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign out_valid  = r_valid;
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_byte_pair_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_pair_packer
// Purpose  : Directed self-checking bench for byte_pair_packer (DEPTH=4, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_pair_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic [15:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic        overflow;
    logic [1:0]  drop_count;
    logic        clear;

    int checks = 0;
    int errors = 0;

    byte_pair_packer #(.DEPTH(4), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clear      (clear)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_word"}, 32'(out_word), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_cnt"}, 32'(drop_count), 32'd0);
    endtask

    task automatic send(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        tick();
    endtask

    initial begin
        logic [15:0] heads [4];

        rst = 1'b1; in_byte = 8'h00; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // Pairing with consumer always ready
        out_ready = 1'b1;
        send(8'h12);
        chk("pair_first_lvl", 32'(level), 32'd0);
        send(8'h34);
        chk("pair_w1_valid", 32'(out_valid), 32'd1);
        chk("pair_w1_word", 32'(out_word), 32'h1234);
        chk("pair_w1_lvl", 32'(level), 32'd1);
        send(8'h56);
        chk("pair_mid_lvl", 32'(level), 32'd0);
        chk("pair_mid_valid", 32'(out_valid), 32'd0);
        send(8'h78);
        chk("pair_w2_word", 32'(out_word), 32'h5678);
        chk("pair_w2_lvl", 32'(level), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("pair_drain_lvl", 32'(level), 32'd0);

        // Pending high byte held across idle cycles
        send(8'hAB);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap_idle_valid", 32'(out_valid), 32'd0);
        end
        send(8'hCD);
        chk("gap_word", 32'(out_word), 32'hABCD);
        chk("gap_lvl", 32'(level), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("gap_drain_lvl", 32'(level), 32'd0);

        // Overflow: fill with consumer stalled, fifth word dropped
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            send(8'(i));
        end
        in_valid = 1'b0;
        chk("ovf_lvl", 32'(level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(drop_count), 32'd1);
        heads[0] = 16'h0102; heads[1] = 16'h0304; heads[2] = 16'h0506; heads[3] = 16'h0708;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_word", 32'(out_word), 32'(heads[i]));
            tick();
        end
        chk("ovf_drain_lvl", 32'(level), 32'd0);
        chk("ovf_drain_valid", 32'(out_valid), 32'd0);

        // Clear alone
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_flag", 32'(overflow), 32'd0);
        chk("clr_cnt", 32'(drop_count), 32'd0);

        // Full FIFO with simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 8'h11; i <= 8'h19; i++) begin
            send(8'(i));
        end
        chk("full_lvl", 32'(level), 32'd4);
        chk("full_head", 32'(out_word), 32'h1112);
        out_ready = 1'b1;
        send(8'h1A);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("pp_lvl", 32'(level), 32'd4);
        chk("pp_flag", 32'(overflow), 32'd0);
        chk("pp_cnt", 32'(drop_count), 32'd0);
        chk("pp_head", 32'(out_word), 32'h1314);

        // Saturation of the 2-bit drop counter
        for (int i = 0; i < 5; i++) begin
            send(8'hA0);
            send(8'hA1);
            if (i == 2) chk("sat_cnt3", 32'(drop_count), 32'd3);
        end
        in_valid = 1'b0;
        chk("sat_cnt", 32'(drop_count), 32'd3);
        chk("sat_flag", 32'(overflow), 32'd1);
        chk("sat_lvl", 32'(level), 32'd4);

        // Clear coincident with a drop
        send(8'hB0);
        clear = 1'b1;
        send(8'hB1);
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clrdrop_flag", 32'(overflow), 32'd1);
        chk("clrdrop_cnt", 32'(drop_count), 32'd1);
        chk("clrdrop_head", 32'(out_word), 32'h1314);

        // Asynchronous reset between the two bytes of a pair
        send(8'h55);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_all_zero("areset");
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        send(8'hEE);
        chk("post_rst_half_lvl", 32'(level), 32'd0);
        send(8'hFF);
        in_valid = 1'b0;
        chk("post_rst_word", 32'(out_word), 32'hEEFF);
        chk("post_rst_valid", 32'(out_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
